sub8_pipe: RTL
==============

SUB8_PIPE -- requirements
Module: sub8_pipe

Interface
REQ-001: The block SHALL have no parameters; operand width is fixed at 8 bits and slice width at 2 bits.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004: in_valid  input  1  an operand set is present on a, b and bin.
REQ-005: in_ready  output  1  the block accepts the operand set this cycle.
REQ-006: a  input  8  minuend, unsigned.
REQ-007: b  input  8  subtrahend, unsigned.
REQ-008: bin  input  1  borrow-in.
REQ-009: out_valid  output  1  d and bout carry a valid result.
REQ-010: out_ready  input  1  downstream consumes the result this cycle.
REQ-011: d  output  8  difference bits, a - b - bin mod 256.
REQ-012: bout  output  1  borrow-out; 1 exactly when a < b + bin.

Function
REQ-013: The result SHALL be {bout,d} = a - b - bin computed in 9-bit two's complement, so that bout = 1 iff (a - b - bin) < 0.
REQ-014: Transfer rules: input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer occurs with out_valid=1 and out_ready=1.
REQ-015: The datapath SHALL be four register stages, S1..S4, each resolving one 2-bit slice with ripple borrow: S1 bits 1:0 using bin, S2 bits 3:2, S3 bits 5:4, S4 bits 7:6 plus bout.
REQ-016: Skew and deskew: unresolved operand bits SHALL be registered forward alongside the slice that still needs them, and resolved difference bits SHALL be delayed so that all 9 result bits for one transfer leave S4 together.
REQ-017: Each stage SHALL carry a valid bit; out_valid SHALL equal the S4 valid bit.
REQ-018: Stall rule: advance = !S4.valid | out_ready. in_ready SHALL equal advance combinationally. All stages SHALL hold their contents when advance=0.
REQ-019: Latency SHALL be exactly 4 rising edges from input transfer to out_valid=1, when there is no stall.
REQ-020: Sustained throughput SHALL be one transfer per cycle while out_ready=1.
REQ-021: Bubbles: a cycle with in_valid=0 and advance=1 SHALL load S1.valid=0, and the bubble SHALL propagate; result order SHALL match acceptance order.
REQ-022: Stability: while out_valid=1 and out_ready=0, d and bout SHALL hold stable.
REQ-023: Invalid stages: d and bout SHALL hold their last value when out_valid=0 (no requirement beyond stability).
REQ-024: Boundary cases: a=b with bin=0 SHALL give d=0x00, bout=0. a=0x00, b=0xFF, bin=1 SHALL give d=0x00, bout=1.
REQ-025: Full-pipe stall: with all four stages valid and out_ready=0, in_ready SHALL be 0 and no data SHALL be lost or duplicated.

Reset
REQ-026: While rst_n=0, all stage valid bits, d and bout SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1.
REQ-027: Reset mid-operation SHALL discard every in-flight result. The first result after reset release SHALL come from the first operand set accepted after release.
REQ-028: Reset deassertion SHALL take effect on the first rising edge after rst_n rises, with no spurious out_valid.

Verification
REQ-029: Simple subtraction, out_ready=1: a=0x35, b=0x12, bin=0 -> d=0x23, bout=0, out_valid=1 exactly 4 edges after acceptance.
REQ-030: Underflow and borrow-in: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1; a=0x80, b=0x7F, bin=1 -> d=0x00, bout=0.
REQ-031: Back-to-back stream: 6 consecutive operand sets (including 0x00-0xFF bin=1 -> d=0x00, bout=1) -> 6 results in order on consecutive cycles, with no gaps.
REQ-032: Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, d/bout stable; on release, results drain in order and none are lost.
REQ-033: Reset mid-flight: pull rst_n low with 3 stages valid -> out_valid=0 immediately; after release, the next accepted a=0x10, b=0x01, bin=0 -> d=0x0F, bout=0 as the first result.
REQ-034: Random comparison: ≥10k random a, b, bin and out_ready patterns compared against a reference model -> zero mismatches and zero ordering errors.

Source files
------------

// File: rtl/sub8_pipe.sv
// sub8_pipe: four-stage 8-bit subtractor, one 2-bit ripple-borrow slice per stage,
// with valid/ready handshaking and a single global advance.
module sub8_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       bin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] d,
   output logic       bout
);
   function automatic logic [2:0] sub2(input logic [1:0] x, input logic [1:0] y, input logic c);
      return {1'b0, x} - {1'b0, y} - {2'b00, c};
   endfunction
   logic       v1, v2, v3, v4, c1, c2, c3, adv;
   logic [1:0] d1;
   logic [3:0] d2;
   logic [5:0] d3;
   logic [7:2] a1, b1;
   logic [7:4] a2, b2;
   logic [7:6] a3, b3;
   logic [2:0] r1, r2, r3, r4;
   assign adv       = !v4 | out_ready;
   assign in_ready  = adv;
   assign out_valid = v4;
   assign r1 = sub2(a[1:0], b[1:0], bin);
   assign r2 = sub2(a1[3:2], b1[3:2], c1);
   assign r3 = sub2(a2[5:4], b2[5:4], c2);
   assign r4 = sub2(a3, b3, c3);
   // d/bout load only from a valid S3 so they keep the last result across bubbles
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {v1, v2, v3, v4, c1, c2, c3, bout} <= '0;
         {d1, d2, d3, d} <= '0;
         {a1, b1, a2, b2, a3, b3} <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
         if (in_valid) begin
            {c1, d1} <= r1;
            a1 <= a[7:2];
            b1 <= b[7:2];
         end
         if (v1) begin
            {c2, d2} <= {r2, d1};
            a2 <= a1[7:4];
            b2 <= b1[7:4];
         end
         if (v2) begin
            {c3, d3} <= {r3, d2};
            a3 <= a2[7:6];
            b3 <= b2[7:6];
         end
         if (v3) {bout, d} <= {r4, d3};
      end
endmodule
